p256_square_arbiter: RTL
========================

Name: p256_square_arbiter

Overview:
Shares one P_256_Square core between NUM_REQ requesters. Each requester owns an 8x32-bit operand/result RAM.
- Arbitrates round-robin among requesters.
- Pulses the core reset to start each job and gates its enable.
- Routes the core's operand reads and result writes to the granted requester's RAM.
- Returns a per-requester done or error pulse.
- Includes a watchdog that aborts a hung job.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT_CYCLES, 4096, max cycles in RUN before abort (>= 512)

Ports:
clk  in  1  clock
rst_n  in  1  reset; one clock; reset is synchronous and active-low
req  in  NUM_REQ  per-requester job request; level, held until done/err
gnt  out  NUM_REQ  one-hot grant, registered
done  out  NUM_REQ  1-cycle pulse: result written
err  out  NUM_REQ  1-cycle pulse: job aborted by timeout
busy  out  1  high whenever a job owns the core
req_a_din  in  32*NUM_REQ  operand read data from each RAM; slice i = [32*i+31:32*i]
req_a_addr  out  3  operand read address, broadcast = core_a_addr
req_d_addr  out  3  result write address, broadcast = core_d_addr
req_d_dout  out  32  result write data, broadcast = core_d_dout
req_d_wren  out  NUM_REQ  per-RAM write enable
core_rst_n  out  1  drives core rst_n, registered
core_ena  out  1  drives core ena, registered
core_a_din  out  32  = req_a_din slice of owner (combinational mux)
core_a_addr  in  3  from core
core_d_addr  in  3  from core
core_d_dout  in  32  from core
core_d_wren  in  1  from core
core_rdy  in  1  from core; sticky high until core reset

Behaviour:
- Reset (rst_n=0 at posedge) values: gnt=0, done=0, err=0, busy=0, core_rst_n=0, core_ena=0, state=IDLE, timer=0, ptr=NUM_REQ-1 (so requester 0 wins first).
- Reset mid-job drops the job silently: no done/err pulse; the core is held in reset.
- The core is held in reset (core_rst_n=0) in every state except RUN. This clears its sticky rdy.
- States (2-bit): IDLE, START, RUN.
- IDLE: if |req, pick the first set bit searching ptr+1, ptr+2, ... modulo NUM_REQ.
  - Register owner index, gnt=onehot(owner), busy=1; go to START.
  - No req: stay in IDLE.
- START (1 cycle): core_rst_n<=1, core_ena<=1, timer<=0; go to RUN.
- RUN: timer increments each cycle.
  - Completion: core_rdy=1 -> done[owner]<=1 for 1 cycle.
  - Timeout: timer==TIMEOUT_CYCLES-1 and core_rdy=0 -> err[owner]<=1 for 1 cycle.
  - Abort: req[owner]=0 -> release with no pulse.
  - Priority when simultaneous: core_rdy > timeout > abort.
  - Release (all three cases): gnt<=0, busy<=0, core_ena<=0, core_rst_n<=0, ptr<=owner; go to IDLE.
- Next grant: IDLE arbitrates on the cycle after release. At minimum one cycle separates gnt deassert from the next gnt assert.
- Requester rule: it must drop req in the cycle after done/err. Otherwise it is re-granted if no other requester is pending.
- Write routing: req_d_wren[i] = core_d_wren & (state==RUN) & (owner==i), combinational. Never more than one bit high. Zero outside RUN.
- Read routing: core_a_din = req_a_din[owner]. It holds the last owner's data in IDLE; the core ignores it while in reset.
- Round-robin fairness: with all req high, grants cycle 0,1,...,NUM_REQ-1,0.
- Requests arriving during RUN are ignored until IDLE. New req bits do not affect the current owner.
- timer width: $clog2(TIMEOUT_CYCLES+1). It does not wrap; it is cleared in START.

Decomposition:
- Package p256_pkg:
  - P constant (256-bit)
  - WORD_W=32, WORDS=8, ADDR_W=3
  - arbiter state enum/localparams IDLE=2'd0, START=2'd1, RUN=2'd2
- One sub-module: p256_rr_pick, combinational round-robin picker.
  - Inputs: req, ptr.
  - Outputs: winner index, valid.

Test Plan:
- Single job: req=4'b0001, RAM0 holds a=2 -> gnt=0001 one cycle after req. One core reset pulse. RAM0 receives 8 writes giving result 4 (word0=4, others 0). done[0] is a 1-cycle pulse. err stays 0.
- Contention: req=4'b1111 held, each dropped after its done -> gnt order 0001,0010,0100,1000. Each RAM i, seeded a=i+3, reads back (i+3)^2. req_d_wren is never multi-hot.
- Fairness restart: after requester 1 finishes, assert req=4'b0011 -> requester 0 is granted (ptr=1 wraps to 0).
- Timeout: stub core with core_rdy tied 0, TIMEOUT_CYCLES=512, req=0010 -> err[1] pulses exactly 513 cycles after gnt rises, plus START. core_rst_n returns to 0. done stays 0.
- Abort and reset: drop req[2] mid-RUN -> release with no pulse; next requester is granted. Separately, assert rst_n=0 mid-RUN for 1 cycle -> all outputs return to reset values at the next posedge.

Source files
------------

// File: rtl/p256_pkg.sv
// p256_pkg: shared constants and arbiter state encoding for the P-256 squaring arbiter
package p256_pkg;
  localparam logic [255:0] P = 256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;
  localparam int WORD_W = 32;
  localparam int WORDS = 8;
  localparam int ADDR_W = 3;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] RUN = 2'd2;
endpackage

// File: rtl/p256_rr_pick.sv
// p256_rr_pick: combinational round-robin picker, first set bit after ptr modulo N
module p256_rr_pick #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);
  logic [IW-1:0] c;
  always_comb begin
    idx_o = '0;
    c = '0;
    for (int k = N; k >= 1; k--) begin
      c = IW'((int'(ptr_i) + k) % N);
      idx_o = req_i[c] ? c : idx_o;
    end
  end
  assign valid_o = |req_i;
endmodule

// File: rtl/p256_square_arbiter.sv
// p256_square_arbiter: round-robin sharing of one P-256 square core among NUM_REQ RAM owners
module p256_square_arbiter
  import p256_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [NUM_REQ-1:0]        err,
  output logic                      busy,
  input  logic [WORD_W*NUM_REQ-1:0] req_a_din,
  output logic [ADDR_W-1:0]         req_a_addr,
  output logic [ADDR_W-1:0]         req_d_addr,
  output logic [WORD_W-1:0]         req_d_dout,
  output logic [NUM_REQ-1:0]        req_d_wren,
  output logic                      core_rst_n,
  output logic                      core_ena,
  output logic [WORD_W-1:0]         core_a_din,
  input  logic [ADDR_W-1:0]         core_a_addr,
  input  logic [ADDR_W-1:0]         core_d_addr,
  input  logic [WORD_W-1:0]         core_d_dout,
  input  logic                      core_d_wren,
  input  logic                      core_rdy
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);
  logic [1:0] state_q, state_d;
  logic [IW-1:0] owner_q, owner_d, ptr_q, ptr_d, pick_idx;
  logic [TW-1:0] timer_q, timer_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d, done_q, done_d, err_q, err_d;
  logic busy_q, busy_d, core_rst_n_q, core_rst_n_d, core_ena_q, core_ena_d;
  logic pick_valid, timeout, release_job;
  p256_rr_pick #(.N(NUM_REQ)) u_pick (
    .req_i(req),
    .ptr_i(ptr_q),
    .idx_o(pick_idx),
    .valid_o(pick_valid)
  );
  assign timeout = timer_q == TW'(TIMEOUT_CYCLES - 1);
  assign release_job = core_rdy || timeout || !req[owner_q];
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d = ptr_q;
    timer_d = timer_q;
    gnt_d = gnt_q;
    busy_d = busy_q;
    core_rst_n_d = core_rst_n_q;
    core_ena_d = core_ena_q;
    done_d = '0;
    err_d = '0;
    case (state_q)
      IDLE: if (pick_valid) begin
        owner_d = pick_idx;
        gnt_d = ONE << pick_idx;
        busy_d = 1'b1;
        state_d = START;
      end
      START: begin
        core_rst_n_d = 1'b1;
        core_ena_d = 1'b1;
        timer_d = '0;
        state_d = RUN;
      end
      RUN: begin
        timer_d = &timer_q ? timer_q : timer_q + 1'b1;
        if (release_job) begin
          done_d[owner_q] = core_rdy;
          err_d[owner_q] = !core_rdy && timeout;
          gnt_d = '0;
          busy_d = 1'b0;
          core_ena_d = 1'b0;
          core_rst_n_d = 1'b0;
          ptr_d = owner_q;
          state_d = IDLE;
        end
      end
      default: begin
        gnt_d = '0;
        busy_d = 1'b0;
        core_ena_d = 1'b0;
        core_rst_n_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q <= IW'(NUM_REQ - 1);
      timer_q <= '0;
      gnt_q <= '0;
      done_q <= '0;
      err_q <= '0;
      busy_q <= 1'b0;
      core_rst_n_q <= 1'b0;
      core_ena_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q <= ptr_d;
      timer_q <= timer_d;
      gnt_q <= gnt_d;
      done_q <= done_d;
      err_q <= err_d;
      busy_q <= busy_d;
      core_rst_n_q <= core_rst_n_d;
      core_ena_q <= core_ena_d;
    end
  end
  assign gnt = gnt_q;
  assign done = done_q;
  assign err = err_q;
  assign busy = busy_q;
  assign core_rst_n = core_rst_n_q;
  assign core_ena = core_ena_q;
  assign req_a_addr = core_a_addr;
  assign req_d_addr = core_d_addr;
  assign req_d_dout = core_d_dout;
  assign req_d_wren = (core_d_wren && state_q == RUN) ? ONE << owner_q : '0;
  assign core_a_din = req_a_din[owner_q*WORD_W +: WORD_W];
endmodule
